// File: rtl/johnson_code_checker.sv
// rtl/johnson_code_checker.sv - Johnson code decoder with sequence lock tracking and saturating error count
module johnson_code_checker #(
  parameter int N          = 5,
  parameter int IW         = 4,
  parameter int LOCK_LEN   = 4,
  parameter int MISS_LIMIT = 3,
  parameter int ALLOW_HOLD = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  jcode,
  output logic          out_valid,
  output logic [IW-1:0] index,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_count
);

  localparam logic [0:0]    SEARCH = 1'b0;
  localparam logic [0:0]    LOCKED = 1'b1;
  localparam int            LCW    = $clog2(LOCK_LEN + 1);
  localparam int            MCW    = $clog2(MISS_LIMIT + 1);
  localparam logic [IW-1:0] LAST   = IW'(2 * N - 1);
  localparam logic [IW-1:0] N_IW   = IW'(N);

  logic [0:0]    state, state_n;
  logic [LCW-1:0] lock_cnt, lock_cnt_n;
  logic [MCW-1:0] miss_cnt, miss_cnt_n;
  logic [IW-1:0] prev, prev_n;
  logic          prev_valid, prev_valid_n;

  logic [N-1:0]  norm;
  logic [IW-1:0] run_len;
  logic [IW-1:0] dec_index;
  logic          dec_legal;
  logic [IW-1:0] succ;
  logic          correct;
  logic          bad;

  // Decode: fold the upper half onto the lower half by inverting when the last stage is set,
  // then a legal code is a run of ones starting at bit 0 and its length gives the index.
  always_comb begin
    norm    = jcode[N-1] ? ~jcode : jcode;
    run_len = '0;
    for (int i = 0; i < N; i++) begin
      run_len = run_len + IW'(norm[i]);
    end
    dec_legal = (((norm >> 1) & ~norm) == '0);
    dec_index = '0;
    if (dec_legal) begin
      dec_index = jcode[N-1] ? (N_IW + run_len) : run_len;
    end
  end

  // Continuity: a sample is correct if it follows the previous legal index (or repeats it when holds are allowed).
  always_comb begin
    succ    = (prev == LAST) ? '0 : (prev + IW'(1));
    correct = dec_legal && prev_valid &&
              ((dec_index == succ) || ((ALLOW_HOLD != 0) && (dec_index == prev)));
  end

  // Lock FSM next state, evaluated for the current sample; only committed when in_valid is high.
  always_comb begin
    state_n      = state;
    lock_cnt_n   = lock_cnt;
    miss_cnt_n   = miss_cnt;
    prev_n       = prev;
    prev_valid_n = prev_valid;
    bad          = 1'b0;
    if (dec_legal) begin
      prev_n       = dec_index;
      prev_valid_n = 1'b1;
    end
    if (state == SEARCH) begin
      if (!dec_legal) begin
        lock_cnt_n   = '0;
        prev_valid_n = 1'b0;
      end else if (correct) begin
        lock_cnt_n = lock_cnt + LCW'(1);
      end else begin
        lock_cnt_n = LCW'(1);
      end
      if (lock_cnt_n == LCW'(LOCK_LEN)) begin
        state_n    = LOCKED;
        miss_cnt_n = '0;
      end
    end else begin
      if (correct) begin
        miss_cnt_n = '0;
      end else begin
        bad        = 1'b1;
        miss_cnt_n = miss_cnt + MCW'(1);
        if (miss_cnt_n == MCW'(MISS_LIMIT)) begin
          state_n    = SEARCH;
          lock_cnt_n = dec_legal ? LCW'(1) : '0;
          if (!dec_legal) begin
            prev_valid_n = 1'b0;
          end
        end
      end
    end
  end

  // Register outputs and state; idle cycles hold everything except the per-sample pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      index      <= '0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= '0;
      state      <= SEARCH;
      lock_cnt   <= '0;
      miss_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      index      <= dec_index;
      illegal    <= ~dec_legal;
      seq_err    <= bad;
      state      <= state_n;
      lock_cnt   <= lock_cnt_n;
      miss_cnt   <= miss_cnt_n;
      prev       <= prev_n;
      prev_valid <= prev_valid_n;
      if ((!dec_legal || bad) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end else begin
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_code_checker.sv
// tb/tb_johnson_code_checker.sv - table-driven scoreboard bench for johnson_code_checker
module tb_johnson_code_checker;

  localparam int N  = 5;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [N-1:0]  jcode;
  logic          out_valid, illegal, seq_err, locked;
  logic [IW-1:0] index;
  logic [7:0]    err_count;
  logic          h_out_valid, h_illegal, h_seq_err, h_locked;
  logic [IW-1:0] h_index;
  logic [7:0]    h_err_count;

  johnson_code_checker #(.N(N), .IW(IW), .LOCK_LEN(4), .MISS_LIMIT(3), .ALLOW_HOLD(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .jcode(jcode),
    .out_valid(out_valid), .index(index), .illegal(illegal), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  johnson_code_checker #(.N(N), .IW(IW), .LOCK_LEN(4), .MISS_LIMIT(3), .ALLOW_HOLD(1)) dut_hold (
    .clock(clock), .reset(reset), .in_valid(in_valid), .jcode(jcode),
    .out_valid(h_out_valid), .index(h_index), .illegal(h_illegal), .seq_err(h_seq_err),
    .locked(h_locked), .err_count(h_err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ov;
    logic [3:0] idx;
    logic       ill;
    logic       se;
    logic       lk;
    logic [7:0] ec;
  } exp_t;

  typedef struct {
    logic       v;
    logic [4:0] code;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [4:0] jc(input int k);
    if (k <= N) return 5'((1 << k) - 1);
    return ~5'((1 << (k - N)) - 1);
  endfunction

  function automatic exp_t ex(input logic ov, input int idx, input logic ill, input logic se,
                              input logic lk, input int ec);
    exp_t e;
    e.ov = ov; e.idx = 4'(idx); e.ill = ill; e.se = se; e.lk = lk; e.ec = 8'(ec);
    return e;
  endfunction

  function automatic vec_t mv(input logic v, input logic [4:0] c, input exp_t e);
    vec_t r;
    r.v = v; r.code = c; r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got ov=%0d idx=%0d ill=%0d se=%0d lk=%0d ec=%0d, required ov=%0d idx=%0d ill=%0d se=%0d lk=%0d ec=%0d",
               name, act.ov, act.idx, act.ill, act.se, act.lk, act.ec,
               req.ov, req.idx, req.ill, req.se, req.lk, req.ec);
    end
  endtask

  function automatic exp_t main_out();
    return {out_valid, index, illegal, seq_err, locked, err_count};
  endfunction

  function automatic exp_t hold_out();
    return {h_out_valid, h_index, h_illegal, h_seq_err, h_locked, h_err_count};
  endfunction

  task automatic step(input logic v, input logic [4:0] code, input exp_t e, input string name);
    exp_t req;
    @(negedge clock);
    in_valid = v;
    jcode    = code;
    sb.push_back(e);
    @(posedge clock);
    #1;
    req = sb.pop_front();
    check(name, main_out(), req);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    jcode    = '0;

    // ordered walk with wrap, lock on 4th sample
    for (int k = 0; k < 10; k++) tbl.push_back(mv(1, jc(k), ex(1, k, 0, 0, (k >= 3), 0)));
    tbl.push_back(mv(1, jc(0), ex(1, 0, 0, 0, 1, 0)));
    tbl.push_back(mv(1, jc(1), ex(1, 1, 0, 0, 1, 0)));
    // single illegal while locked, then successor of last good
    tbl.push_back(mv(1, 5'b00101, ex(1, 0, 1, 1, 1, 1)));
    tbl.push_back(mv(1, jc(2), ex(1, 2, 0, 0, 1, 1)));
    // skip 3 -> 5, then 6, 7
    tbl.push_back(mv(1, jc(3), ex(1, 3, 0, 0, 1, 1)));
    tbl.push_back(mv(1, jc(5), ex(1, 5, 0, 1, 1, 2)));
    tbl.push_back(mv(1, jc(6), ex(1, 6, 0, 0, 1, 2)));
    tbl.push_back(mv(1, jc(7), ex(1, 7, 0, 0, 1, 2)));
    // in_valid gap: hold
    tbl.push_back(mv(0, 5'b00101, ex(0, 7, 0, 0, 1, 2)));
    tbl.push_back(mv(0, 5'b01010, ex(0, 7, 0, 0, 1, 2)));
    tbl.push_back(mv(1, jc(8), ex(1, 8, 0, 0, 1, 2)));
    // three illegal codes drop lock
    tbl.push_back(mv(1, 5'b01010, ex(1, 0, 1, 1, 1, 3)));
    tbl.push_back(mv(1, 5'b10101, ex(1, 0, 1, 1, 1, 4)));
    tbl.push_back(mv(1, 5'b01010, ex(1, 0, 1, 1, 0, 5)));
    // fresh run of 4 re-locks
    tbl.push_back(mv(1, jc(2), ex(1, 2, 0, 0, 0, 5)));
    tbl.push_back(mv(1, jc(3), ex(1, 3, 0, 0, 0, 5)));
    tbl.push_back(mv(1, jc(4), ex(1, 4, 0, 0, 0, 5)));
    tbl.push_back(mv(1, jc(5), ex(1, 5, 0, 0, 1, 5)));
    // repeat without hold allowance is a sequence error
    tbl.push_back(mv(1, jc(5), ex(1, 5, 0, 1, 1, 6)));
    tbl.push_back(mv(1, jc(6), ex(1, 6, 0, 0, 1, 6)));

    repeat (2) @(posedge clock);
    #1;
    check("reset_state", main_out(), ex(0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].code, tbl[i].e, $sformatf("vec%0d", i));
    end

    // reset mid-stream beats in_valid
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    jcode    = jc(7);
    @(posedge clock);
    #1;
    check("midstream_reset", main_out(), ex(0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;

    // lock counter restarts from zero after reset; both instances lock
    for (int k = 0; k < 4; k++) step(1, jc(k), ex(1, k, 0, 0, (k == 3), 0), $sformatf("relock%0d", k));
    check("hold_locked", hold_out(), ex(1, 3, 0, 0, 1, 0));
    step(1, jc(3), ex(1, 3, 0, 1, 1, 1), "repeat_nohold");
    check("repeat_hold", hold_out(), ex(1, 3, 0, 0, 1, 0));
    step(1, jc(4), ex(1, 4, 0, 0, 1, 1), "after_repeat_nohold");
    check("after_repeat_hold", hold_out(), ex(1, 4, 0, 0, 1, 0));

    // saturation: 300 illegal samples in SEARCH, never a seq_err
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1, 5'b01010, ex(1, 0, 1, 0, 0, (i + 1 > 255) ? 255 : i + 1), $sformatf("sat%0d", i));
    end
    step(0, 5'b00000, ex(0, 0, 1, 0, 0, 255), "sat_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/johnson_code_checker.md
Name: johnson_code_checker

Overview:
- Receive-side companion to the team's N-stage Johnson counter.
- Samples a Johnson-coded bus, decodes it to a binary index, and flags illegal codes.
- Tracks sequence continuity with a lock state machine, and keeps a saturating error count.
- Sits downstream of a Johnson counter (or a remote copy of its state) as a monitor/decoder.

Parameters:
- N, 5: Johnson counter stages; legal sequence length is 2N; N must be at least 2.
- IW, 4: index width; must satisfy 2^IW >= 2N.
- LOCK_LEN, 4: consecutive correct legal samples needed to enter LOCKED (at least 2).
- MISS_LIMIT, 3: consecutive bad samples in LOCKED that force return to SEARCH (at least 1).
- ALLOW_HOLD, 0: when 1, a repeat of the previous code counts as correct (counter stalled); when 0 it is a sequence error.

Ports:
- clock, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: jcode is sampled this cycle.
- jcode, input, N: Johnson code. Bit 0 is the stage fed by the inverted last stage; bit N-1 is the last stage.
- out_valid, output, 1: registered copy of in_valid.
- index, output, IW: decoded position 0..2N-1; 0 when the code is illegal.
- illegal, output, 1: sampled code is not one of the 2N legal codes.
- seq_err, output, 1: pulse; LOCKED and the sample is not the expected successor.
- locked, output, 1: FSM is in LOCKED.
- err_count, output, 8: saturating error counter.

Behaviour:
- Legal codes and index:
  - Index k = 0..N: bits 0..k-1 are 1, the rest are 0.
  - Index k = N+1..2N-1: bits 0..k-N-1 are 0, the rest are 1.
  - Decode when jcode[N-1]=0: index = count of ones, and the code is legal only if the ones are contiguous from bit 0.
  - Decode when jcode[N-1]=1: index = N + count of zeros, and the code is legal only if the zeros are contiguous from bit 0.
  - All other codes are illegal.
  - Successor of index k is (k+1) mod 2N, so 2N-1 wraps to 0.
- Latency: all outputs are registered and update one cycle after an in_valid sample. When in_valid=0, out_valid=0, seq_err=0, and index, illegal and FSM state hold.
- Reset values: out_valid=0, index=0, illegal=0, seq_err=0, locked=0, err_count=0, state=SEARCH, lock_cnt=0, miss_cnt=0, prev_valid=0. Reset asserted mid-stream wins over in_valid on the same edge.
- Correct sample: legal, prev_valid=1, and index == successor(prev); also correct if ALLOW_HOLD=1 and index == prev. Legal samples update prev and set prev_valid.
- FSM SEARCH:
  - Legal and correct: lock_cnt+1.
  - Legal but not correct: lock_cnt=1.
  - Illegal: lock_cnt=0 and prev_valid=0.
  - When lock_cnt reaches LOCK_LEN on this sample: go to LOCKED, with locked=1 on the same output cycle; clear miss_cnt.
  - seq_err is never asserted in SEARCH.
- FSM LOCKED:
  - Correct sample: miss_cnt=0.
  - Bad sample (illegal or not correct): seq_err=1, miss_cnt+1.
  - When miss_cnt reaches MISS_LIMIT: go to SEARCH, with locked=0 on the same output cycle. lock_cnt=1 if that sample was legal, else 0.
  - A legal-but-wrong sample re-seeds prev, so a single skip produces exactly one seq_err.
- err_count: +1 per valid sample that is illegal (any state) or has seq_err. A sample that is both illegal and seq_err counts once. Saturates at 255; cleared only by reset.

Test Plan:
1. N=5, reset, then feed the 10 legal codes in order (00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000), then wrap -> index 0..9 one cycle later; locked rises on the 4th sample; seq_err=0 across the 9->0 wrap; err_count=0.
2. Locked, then feed 00101 -> illegal=1, index=0, seq_err=1, err_count=1; next correct successor of the last good code keeps locked=1 and clears miss_cnt.
3. Locked at index 3, then feed index 5 (skip), then 6, 7 -> exactly one seq_err pulse, err_count+1, locked stays 1.
4. Locked, then three consecutive illegal codes (01010, 10101, 01010) -> locked falls on the third; err_count+3; a fresh legal run of 4 re-locks.
5. Repeat code 00111 twice: with ALLOW_HOLD=0 -> seq_err=1; with ALLOW_HOLD=1 -> no error and lock maintained.
6. in_valid gaps mid-sequence -> outputs and state hold; assert reset for one cycle mid-stream -> all outputs 0 and state=SEARCH next cycle; 300 illegal samples -> err_count saturates at 255.
